// File: rtl/closed_list_search.sv
// Linear-search / insert unit for the A* closed list: scans valid (x,y) entries one per clock,
// reports hit/miss with the lowest matching index, optionally appends on a miss, or clears the list.
module closed_list_search #(
    parameter int COORD_W = 8,
    parameter int DEPTH   = 400,
    parameter int IDX_W   = 9
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [COORD_W-1:0] key_x,
    input  logic [COORD_W-1:0] key_y,
    output logic               busy,
    output logic               done,
    output logic               found,
    output logic [IDX_W-1:0]   match_idx,
    output logic               inserted,
    output logic               full_err,
    output logic [IDX_W-1:0]   count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] OP_INSERT = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;

    state_t                   r_state;
    state_t                   w_next_state;
    logic [1:0]               r_op;
    logic [2*COORD_W-1:0]     r_key;
    logic [IDX_W-1:0]         r_idx;
    logic [IDX_W-1:0]         r_count;
    logic                     r_found;
    logic [IDX_W-1:0]         r_match_idx;
    logic                     r_inserted;
    logic                     r_full_err;
    logic [2*COORD_W-1:0]     r_entry [DEPTH];

    logic                     w_hit;
    logic                     w_last;
    logic                     w_full;
    logic                     w_wr_en;

    assign w_hit   = (r_entry[r_idx] == r_key);
    assign w_last  = (r_idx == r_count - IDX_W'(1));
    assign w_full  = (r_count == IDX_W'(DEPTH));
    // Gated by Reset so a reset landing on the WRITE cycle leaves storage untouched.
    assign w_wr_en = Reset && (r_state == S_WRITE) && !w_full;

    // State register plus datapath registers
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_key       <= '0;
            r_idx       <= '0;
            r_count     <= '0;
            r_found     <= 1'b0;
            r_match_idx <= '0;
            r_inserted  <= 1'b0;
            r_full_err  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op        <= op;
                        r_key       <= {key_x, key_y};
                        r_idx       <= '0;
                        r_found     <= 1'b0;
                        r_match_idx <= '0;
                        r_inserted  <= 1'b0;
                        r_full_err  <= 1'b0;
                        if (op == OP_CLEAR) begin
                            r_count <= '0;
                        end
                    end
                end
                S_SCAN: begin
                    if (w_hit) begin
                        r_found     <= 1'b1;
                        r_match_idx <= r_idx;
                    end else if (!w_last) begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                S_WRITE: begin
                    if (w_full) begin
                        r_full_err <= 1'b1;
                    end else begin
                        r_match_idx <= r_count;
                        r_inserted  <= 1'b1;
                        r_count     <= r_count + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: entry storage has no reset; count alone marks which entries are valid.
    always_ff @(posedge Clk) begin
        if (w_wr_en) begin
            r_entry[r_count] <= r_key;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (op == OP_CLEAR) begin
                        w_next_state = S_DONE;
                    end else if (r_count == '0) begin
                        w_next_state = (op == OP_INSERT) ? S_WRITE : S_DONE;
                    end else begin
                        w_next_state = S_SCAN;
                    end
                end
            end
            S_SCAN: begin
                if (w_hit) begin
                    w_next_state = S_DONE;
                end else if (w_last) begin
                    w_next_state = (r_op == OP_INSERT) ? S_WRITE : S_DONE;
                end
            end
            S_WRITE: w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy      = (r_state == S_SCAN) || (r_state == S_WRITE);
        done      = (r_state == S_DONE);
        found     = r_found;
        match_idx = r_match_idx;
        inserted  = r_inserted;
        full_err  = r_full_err;
        count     = r_count;
    end

endmodule
